id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_pkg.sv | 56 +++++
 rtl/id_ex_stage_decode.sv | 89 ++++++++
 rtl/id_ex_stage.sv | 114 +++++++++++
 tb/tb_id_ex_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pkg.sv
// Shared pipeline definitions: field positions, opcode/funct values and ALU op encodings.
package id_ex_pkg;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int FUNCT_MSB  = 5;
  localparam int IMM_MSB    = 15;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4
  } alu_op_e;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    logic        branch;
    logic [3:0]  alu_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wreg;
    logic        illegal;
  } id_ex_t;

  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/id_ex_stage_decode.sv
// Combinational instruction decode: control bits, destination register, illegal flag
// and whether the instruction reads rt as a source operand.
module id_decode
  import id_ex_pkg::*;
(
  input  logic [31:0] instr,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src,
  output logic        branch,
  output logic [3:0]  alu_op,
  output logic [4:0]  wreg,
  output logic        illegal,
  output logic        uses_rt
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       reg_write_raw;
  logic       unused_shamt;

  assign opcode       = instr[OPCODE_MSB:OPCODE_LSB];
  assign funct        = instr[FUNCT_MSB:0];
  assign rt           = instr[RT_MSB:RT_LSB];
  assign rd           = instr[RD_MSB:RD_LSB];
  assign unused_shamt = ^instr[10:6];

  always_comb begin
    reg_write_raw = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    alu_src       = 1'b0;
    branch        = 1'b0;
    alu_op        = ALU_ADD;
    wreg          = 5'd0;
    illegal       = 1'b0;
    uses_rt       = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        uses_rt = 1'b1;
        // The all-zero word is the canonical NOP, not an unknown funct.
        if (instr != 32'd0) begin
          reg_write_raw = 1'b1;
          wreg          = rd;
          case (funct)
            FUNCT_ADD: alu_op = ALU_ADD;
            FUNCT_SUB: alu_op = ALU_SUB;
            FUNCT_AND: alu_op = ALU_AND;
            FUNCT_OR:  alu_op = ALU_OR;
            FUNCT_SLT: alu_op = ALU_SLT;
            default: begin
              reg_write_raw = 1'b0;
              wreg          = 5'd0;
              illegal       = 1'b1;
            end
          endcase
        end
      end
      OP_ADDI: begin
        reg_write_raw = 1'b1;
        alu_src       = 1'b1;
        wreg          = rt;
      end
      OP_LW: begin
        reg_write_raw = 1'b1;
        mem_read      = 1'b1;
        alu_src       = 1'b1;
        wreg          = rt;
      end
      OP_SW: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        uses_rt   = 1'b1;
      end
      OP_BEQ: begin
        branch  = 1'b1;
        alu_op  = ALU_SUB;
        uses_rt = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign reg_write = reg_write_raw & (wreg != 5'd0);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush and hold control.
module id_ex_stage
  import id_ex_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  input  logic        hold,
  output logic        stall_o,
  output logic        ex_valid,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_alu_src,
  output logic        ex_branch,
  output logic [3:0]  ex_alu_op,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_wreg,
  output logic        ex_illegal
);

  id_ex_t     ex_q;
  id_ex_t     ex_next;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       hazard;

  logic       dec_reg_write;
  logic       dec_mem_read;
  logic       dec_mem_write;
  logic       dec_alu_src;
  logic       dec_branch;
  logic [3:0] dec_alu_op;
  logic [4:0] dec_wreg;
  logic       dec_illegal;
  logic       dec_uses_rt;

  assign rs = id_instr[RS_MSB:RS_LSB];
  assign rt = id_instr[RT_MSB:RT_LSB];

  id_decode u_decode (
    .instr     (id_instr),
    .reg_write (dec_reg_write),
    .mem_read  (dec_mem_read),
    .mem_write (dec_mem_write),
    .alu_src   (dec_alu_src),
    .branch    (dec_branch),
    .alu_op    (dec_alu_op),
    .wreg      (dec_wreg),
    .illegal   (dec_illegal),
    .uses_rt   (dec_uses_rt)
  );

  // A load in EX whose result is needed by the instruction sitting in ID.
  assign hazard = ex_q.valid & ex_q.mem_read & (ex_q.wreg != 5'd0) & id_valid &
                  ((ex_q.wreg == rs) | (dec_uses_rt & (ex_q.wreg == rt)));

  assign stall_o = reset_n & ~flush & (hold | hazard);

  always_comb begin
    ex_next           = '0;
    ex_next.valid     = 1'b1;
    ex_next.reg_write = dec_reg_write;
    ex_next.mem_read  = dec_mem_read;
    ex_next.mem_write = dec_mem_write;
    ex_next.alu_src   = dec_alu_src;
    ex_next.branch    = dec_branch;
    ex_next.alu_op    = dec_alu_op;
    ex_next.rs_data   = rs_data;
    ex_next.rt_data   = rt_data;
    ex_next.imm       = sign_ext16(id_instr[IMM_MSB:0]);
    ex_next.rs        = rs;
    ex_next.rt        = rt;
    ex_next.wreg      = dec_wreg;
    ex_next.illegal   = dec_illegal;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      ex_q <= '0;
    else if (flush)
      ex_q <= '0;
    else if (hold)
      ex_q <= ex_q;
    else if (hazard || !id_valid)
      ex_q <= '0;
    else
      ex_q <= ex_next;
  end

  assign ex_valid     = ex_q.valid;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_alu_src   = ex_q.alu_src;
  assign ex_branch    = ex_q.branch;
  assign ex_alu_op    = ex_q.alu_op;
  assign ex_rs_data   = ex_q.rs_data;
  assign ex_rt_data   = ex_q.rt_data;
  assign ex_imm       = ex_q.imm;
  assign ex_rs        = ex_q.rs;
  assign ex_rt        = ex_q.rt;
  assign ex_wreg      = ex_q.wreg;
  assign ex_illegal   = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; ctl packs {valid,reg_write,mem_read,mem_write,alu_src,branch,illegal}.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        hold;
  logic        stall_o;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_wreg;
  logic        ex_illegal;
  logic [6:0]  ctl;
  int          checks = 0;
  int          errors = 0;

  assign ctl = {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch, ex_illegal};

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_instr(id_instr),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush), .hold(hold), .stall_o(stall_o),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
    .ex_alu_op(ex_alu_op), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg), .ex_illegal(ex_illegal)
  );

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; hold = 1'b1; flush = 1'b0; id_valid = 1'b1;
    id_instr = i_ins(6'h08, 5'd1, 5'd2, 16'h0010); rs_data = 32'h11; rt_data = 32'h22;
    tick(); tick();
    checks++;
    if (ctl !== 7'b0000000) begin errors++; $display("[TB] FAIL reset_ctl got %b expected %b", ctl, 7'b0); end
    checks++;
    if ({ex_alu_op, ex_rs_data, ex_imm, ex_wreg} !== '0) begin
      errors++; $display("[TB] FAIL reset_data got %h expected 0", {ex_alu_op, ex_rs_data, ex_imm, ex_wreg});
    end
    checks++;
    if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %b expected 0", stall_o); end
    reset_n = 1'b1; hold = 1'b0; id_valid = 1'b0;
    tick();
    checks++;
    if (ctl !== 7'b0000000) begin errors++; $display("[TB] FAIL invalid_bubble got %b expected 0", ctl); end
  endtask

  task automatic test_addi();
    id_valid = 1'b1; id_instr = i_ins(6'h08, 5'd1, 5'd2, 16'hFFFC); rs_data = 32'd5; rt_data = 32'd7;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL addi_stall got %b expected 0", stall_o); end
    tick();
    checks++;
    if (ctl !== 7'b1100100) begin errors++; $display("[TB] FAIL addi_ctl got %b expected %b", ctl, 7'b1100100); end
    checks++;
    if ({ex_imm, ex_wreg, ex_rs_data, ex_rs, ex_rt, ex_alu_op} !== {32'hFFFFFFFC, 5'd2, 32'd5, 5'd1, 5'd2, 4'd0}) begin
      errors++; $display("[TB] FAIL addi_data got imm=%h wreg=%0d rsd=%0d rs=%0d rt=%0d op=%0d expected imm=fffffffc wreg=2 rsd=5 rs=1 rt=2 op=0",
                         ex_imm, ex_wreg, ex_rs_data, ex_rs, ex_rt, ex_alu_op);
    end
  endtask

  task automatic test_rtype_decode();
    logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    for (int i = 0; i < 5; i++) begin
      id_instr = r_ins(5'd1, 5'd2, 5'(i + 3), fns[i]);
      tick();
      checks++;
      if ({ctl, ex_alu_op, ex_wreg} !== {7'b1100000, 4'(i), 5'(i + 3)}) begin
        errors++; $display("[TB] FAIL rtype_%0d got ctl=%b op=%0d wreg=%0d expected ctl=1100000 op=%0d wreg=%0d",
                           i, ctl, ex_alu_op, ex_wreg, i, i + 3);
      end
    end
    id_instr = r_ins(5'd1, 5'd2, 5'd0, 6'h22);
    tick();
    checks++;
    if (ctl !== 7'b1000000) begin errors++; $display("[TB] FAIL rd0_ctl got %b expected 1000000", ctl); end
    id_instr = i_ins(6'h2B, 5'd1, 5'd2, 16'h0004);
    tick();
    checks++;
    if (ctl !== 7'b1001100) begin errors++; $display("[TB] FAIL sw_ctl got %b expected 1001100", ctl); end
    id_instr = i_ins(6'h04, 5'd1, 5'd2, 16'h8000);
    tick();
    checks++;
    if ({ctl, ex_alu_op, ex_imm} !== {7'b1000010, 4'd1, 32'hFFFF8000}) begin
      errors++; $display("[TB] FAIL beq got ctl=%b op=%0d imm=%h expected ctl=1000010 op=1 imm=ffff8000", ctl, ex_alu_op, ex_imm);
    end
  endtask

  task automatic test_load_use();
    id_instr = i_ins(6'h23, 5'd1, 5'd3, 16'h0008);
    tick();
    id_instr = r_ins(5'd3, 5'd4, 5'd5, 6'h20); rs_data = 32'hAA;
    #1;
    checks++;
    if (stall_o !== 1'b1) begin errors++; $display("[TB] FAIL lu_stall got %b expected 1", stall_o); end
    tick();
    checks++;
    if ({ctl, ex_rs_data, ex_wreg, stall_o} !== {7'b0000000, 32'd0, 5'd0, 1'b0}) begin
      errors++; $display("[TB] FAIL lu_bubble got ctl=%b rsd=%h wreg=%0d stall=%b expected all 0", ctl, ex_rs_data, ex_wreg, stall_o);
    end
    tick();
    checks++;
    if ({ctl, ex_wreg, ex_rs, ex_rs_data} !== {7'b1100000, 5'd5, 5'd3, 32'hAA}) begin
      errors++; $display("[TB] FAIL lu_issue got ctl=%b wreg=%0d rs=%0d expected ctl=1100000 wreg=5 rs=3", ctl, ex_wreg, ex_rs);
    end
    id_instr = i_ins(6'h23, 5'd1, 5'd6, 16'h0000);
    tick();
    id_instr = i_ins(6'h08, 5'd1, 5'd6, 16'h0001);
    #1;
    checks++;
    if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL lu_addi_rt got %b expected 0", stall_o); end
    id_instr = i_ins(6'h2B, 5'd1, 5'd6, 16'h0000);
    #1;
    checks++;
    if (stall_o !== 1'b1) begin errors++; $display("[TB] FAIL lu_sw_rt got %b expected 1", stall_o); end
    id_valid = 1'b0;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL lu_invalid got %b expected 0", stall_o); end
    tick();
    id_valid = 1'b1;
  endtask

  task automatic test_lw_r0();
    id_instr = i_ins(6'h23, 5'd1, 5'd0, 16'h0000);
    tick();
    checks++;
    if (ctl !== 7'b1010100) begin errors++; $display("[TB] FAIL lw_r0_ctl got %b expected 1010100", ctl); end
    id_instr = r_ins(5'd0, 5'd0, 5'd7, 6'h20);
    #1;
    checks++;
    if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL lw_r0_stall got %b expected 0", stall_o); end
    tick();
    checks++;
    if ({ctl, ex_wreg} !== {7'b1100000, 5'd7}) begin
      errors++; $display("[TB] FAIL lw_r0_next got ctl=%b wreg=%0d expected ctl=1100000 wreg=7", ctl, ex_wreg);
    end
  endtask

  task automatic test_flush_hold();
    id_instr = i_ins(6'h23, 5'd1, 5'd3, 16'h0000);
    tick();
    id_instr = r_ins(5'd3, 5'd4, 5'd5, 6'h20); flush = 1'b1; hold = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL fh_stall got %b expected 0", stall_o); end
    tick();
    flush = 1'b0; hold = 1'b0;
    #1;
    checks++;
    if ({ctl, stall_o} !== 8'b0) begin errors++; $display("[TB] FAIL fh_bubble got ctl=%b stall=%b expected 0", ctl, stall_o); end
  endtask

  task automatic test_hold();
    id_instr = r_ins(5'd1, 5'd2, 5'd3, 6'h22); rs_data = 32'd10; rt_data = 32'd20;
    tick();
    hold = 1'b1; id_instr = i_ins(6'h08, 5'd9, 5'd9, 16'h0055); rs_data = 32'd99;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (stall_o !== 1'b1) begin errors++; $display("[TB] FAIL hold_stall_%0d got %b expected 1", i, stall_o); end
      tick();
      checks++;
      if ({ctl, ex_alu_op, ex_rs_data, ex_rt_data, ex_wreg} !== {7'b1100000, 4'd1, 32'd10, 32'd20, 5'd3}) begin
        errors++; $display("[TB] FAIL hold_keep_%0d got ctl=%b op=%0d rsd=%0d rtd=%0d wreg=%0d expected 1100000 1 10 20 3",
                           i, ctl, ex_alu_op, ex_rs_data, ex_rt_data, ex_wreg);
      end
    end
    hold = 1'b0;
  endtask

  task automatic test_illegal_reset();
    id_instr = 32'hFC00_0000;
    tick();
    checks++;
    if (ctl !== 7'b1000001) begin errors++; $display("[TB] FAIL illegal_op got %b expected 1000001", ctl); end
    id_instr = r_ins(5'd1, 5'd2, 5'd5, 6'h3F);
    tick();
    checks++;
    if (ctl !== 7'b1000001) begin errors++; $display("[TB] FAIL illegal_funct got %b expected 1000001", ctl); end
    id_instr = 32'd0;
    tick();
    checks++;
    if (ctl !== 7'b1000000) begin errors++; $display("[TB] FAIL nop got %b expected 1000000", ctl); end
    id_instr = 32'hFC00_0000;
    tick();
    checks++;
    if (ex_illegal !== 1'b1) begin errors++; $display("[TB] FAIL illegal_again got %b expected 1", ex_illegal); end
    reset_n = 1'b0; hold = 1'b1;
    tick();
    checks++;
    if ({ctl, ex_alu_op, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_wreg, stall_o} !== '0) begin
      errors++; $display("[TB] FAIL reset_clear got ctl=%b imm=%h stall=%b expected all 0", ctl, ex_imm, stall_o);
    end
    reset_n = 1'b1; hold = 1'b0; id_instr = i_ins(6'h08, 5'd4, 5'd8, 16'h0003);
    tick();
    checks++;
    if ({ctl, ex_wreg, ex_imm} !== {7'b1100100, 5'd8, 32'd3}) begin
      errors++; $display("[TB] FAIL post_reset got ctl=%b wreg=%0d imm=%h expected 1100100 8 3", ctl, ex_wreg, ex_imm);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] imms [3] = '{16'h7FFF, 16'h8001, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      id_instr = i_ins(6'h08, 5'd2, 5'(i + 10), imms[i]); rs_data = 32'(i * 3);
      tick();
      checks++;
      if ({ctl, ex_wreg, ex_imm, ex_rs_data} !== {7'b1100100, 5'(i + 10), {{16{imms[i][15]}}, imms[i]}, 32'(i * 3)}) begin
        errors++; $display("[TB] FAIL b2b_%0d got ctl=%b wreg=%0d imm=%h rsd=%0d", i, ctl, ex_wreg, ex_imm, ex_rs_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_rtype_decode();
    test_load_use();
    test_lw_r0();
    test_flush_hold();
    test_hold();
    test_illegal_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
